// File: rtl/sort_engine_loader.sv
// sort_engine_loader: upstream loader for gnome_sort_engine.
// Accepts one Avalon-ST packet at a time, clears the engine, streams the
// packet words into the engine write port, strobes run, then holds off input
// until the engine's sorted output packet has completed.
// Build option: define SORT_LOADER_OVERFLOW_DROP_EN to drop oversize packets
// (no run) instead of truncating them to the first CAP words.
module sort_engine_loader #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_sop_i,
    input  logic              in_eop_i,
    output logic              in_ready_o,
    output logic              sort_srst_o,
    output logic              sort_wr_req_o,
    output logic [DWIDTH-1:0] sort_wr_data_o,
    output logic              sort_run_o,
    input  logic              sort_out_valid_i,
    input  logic              sort_out_ready_i,
    input  logic              sort_out_eop_i,
    output logic [AWIDTH:0]   pkt_len_o,
    output logic              overflow_o,
    output logic              busy_o
);

    // Packet length value that means "engine full".
    localparam logic [AWIDTH:0] CapLen = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StRun,
        StWaitOut
    } state_e;

    state_e              state_q, state_d;
    logic                first_q, first_d;        // next LOAD word is the packet's first
    logic [AWIDTH:0]     pkt_len_q, pkt_len_d;
    logic                overflow_q, overflow_d;
    logic                wr_req_q, wr_req_d;
    logic [DWIDTH-1:0]   wr_data_q, wr_data_d;
    logic                run_q, run_d;

    logic                in_hs;
    logic                full;
    logic                restart;
    logic                out_eop_hs;

    assign in_hs      = in_valid_i && in_ready_o;
    assign full       = (pkt_len_q == CapLen);
    // A sop on a non-first word aborts the current load and restarts it.
    assign restart    = in_valid_i && in_sop_i && !first_q;
    assign out_eop_hs = sort_out_valid_i && sort_out_ready_i && sort_out_eop_i;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            first_q    <= 1'b0;
            pkt_len_q  <= '0;
            overflow_q <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_data_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            pkt_len_q  <= pkt_len_d;
            overflow_q <= overflow_d;
            wr_req_q   <= wr_req_d;
            wr_data_q  <= wr_data_d;
            run_q      <= run_d;
        end
    end

    // Next-state logic for the FSM and the registered datapath.
    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        pkt_len_d  = pkt_len_q;
        overflow_d = overflow_q;
        wr_req_d   = 1'b0;
        wr_data_d  = wr_data_q;
        // run lands one cycle after RUN, i.e. after the last write has registered.
        run_d      = (state_q == StRun);

        unique case (state_q)
            StIdle: begin
                if (in_valid_i && in_sop_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                pkt_len_d  = '0;
                overflow_d = 1'b0;
                first_d    = 1'b1;
                state_d    = StLoad;
            end
            StLoad: begin
                if (restart) begin
                    state_d = StClear;
                end else if (in_hs) begin
                    first_d = 1'b0;
                    if (!full) begin
                        wr_req_d  = 1'b1;
                        wr_data_d = in_data_i;
                        pkt_len_d = pkt_len_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (in_eop_i) begin
`ifdef SORT_LOADER_OVERFLOW_DROP_EN
                        // Oversize packet: leave the engine loaded but never run it.
                        state_d = (overflow_q || full) ? StIdle : StRun;
`else
                        state_d = StRun;
`endif
                    end
                end
            end
            StRun: begin
                state_d = StWaitOut;
            end
            StWaitOut: begin
                if (out_eop_hs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: ready is combinational from the input; the rest decode registers.
    always_comb begin
        in_ready_o = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                StIdle:  in_ready_o = !in_sop_i;
                StLoad:  in_ready_o = !(in_sop_i && !first_q);
                default: in_ready_o = 1'b0;
            endcase
        end
        sort_srst_o    = (state_q == StClear);
        busy_o         = (state_q != StIdle);
        sort_wr_req_o  = wr_req_q;
        sort_wr_data_o = wr_data_q;
        sort_run_o     = run_q;
        pkt_len_o      = pkt_len_q;
        overflow_o     = overflow_q;
    end

endmodule

// File: tb/tb_sort_engine_loader.sv
// Testbench for sort_engine_loader (AWIDTH=3, CAP=8). Stimulus pushes the
// expected engine-side events (srst / write data / run) into a queue; a
// monitor pops and compares them whenever the DUT drives one of them.
module tb_sort_engine_loader;

    localparam int unsigned AW  = 3;
    localparam int unsigned DW  = 8;
    localparam int          CAP = 8;

    localparam int EvSrst = 1000;
    localparam int EvRun  = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid, in_sop, in_eop;
    logic          in_ready_o;
    logic          sort_srst_o, sort_wr_req_o, sort_run_o;
    logic [DW-1:0] sort_wr_data_o;
    logic          out_valid, out_ready, out_eop;
    logic [AW:0]   pkt_len_o;
    logic          overflow_o, busy_o;

    sort_engine_loader #(
        .AWIDTH (AW),
        .DWIDTH (DW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_data_i        (in_data),
        .in_valid_i       (in_valid),
        .in_sop_i         (in_sop),
        .in_eop_i         (in_eop),
        .in_ready_o       (in_ready_o),
        .sort_srst_o      (sort_srst_o),
        .sort_wr_req_o    (sort_wr_req_o),
        .sort_wr_data_o   (sort_wr_data_o),
        .sort_run_o       (sort_run_o),
        .sort_out_valid_i (out_valid),
        .sort_out_ready_i (out_ready),
        .sort_out_eop_i   (out_eop),
        .pkt_len_o        (pkt_len_o),
        .overflow_o       (overflow_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_q[$];
    logic [7:0]  pkt_q[$];
    int          cyc = 0;
    int          srst_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, run_cyc = 0;
    bit          wr_since_srst = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic mon_evt(input int code, input string name);
        int e;
        if (exp_q.size() == 0) begin
            check({"unexpected ", name}, code, -1);
        end else begin
            e = exp_q.pop_front();
            check(name, code, e);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (sort_srst_o) begin
            mon_evt(EvSrst, "srst");
            srst_cyc      = cyc;
            wr_since_srst = 1'b0;
        end
        if (sort_wr_req_o) begin
            mon_evt(int'(sort_wr_data_o), "write");
            if (!wr_since_srst) first_wr_cyc = cyc;
            wr_since_srst = 1'b1;
            last_wr_cyc   = cyc;
        end
        if (sort_run_o) begin
            mon_evt(EvRun, "run");
            run_cyc = cyc;
        end
    end

    // Present one word at a falling edge and hold it until it is accepted.
    task automatic send(input logic [7:0] d, input logic sop, input logic eop,
                        output bit rdy0);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        #1;
        rdy0 = in_ready_o;
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready_o) check("ready timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Send pkt_q as one packet; expect srst, up to CAP writes and a run.
    task automatic send_pkt();
        bit r;
        int n = pkt_q.size();
        exp_q.push_back(EvSrst);
        for (int i = 0; i < n; i++) begin
            if (i < CAP) exp_q.push_back(int'(pkt_q[i]));
            send(pkt_q[i], i == 0, i == n - 1, r);
        end
`ifdef SORT_LOADER_OVERFLOW_DROP_EN
        if (n <= CAP) exp_q.push_back(EvRun);
`else
        exp_q.push_back(EvRun);
`endif
        idle_in();
    endtask

    task automatic out_eop_hs();
        @(negedge clk);
        out_valid = 1'b1;
        out_ready = 1'b1;
        out_eop   = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        out_ready = 1'b0;
        out_eop   = 1'b0;
        #1;
        check("idle after out eop", int'(busy_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r;
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        out_valid = 1'b0; out_ready = 1'b0; out_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", int'(in_ready_o), 0);
        check("reset srst", int'(sort_srst_o), 0);
        check("reset wr_req", int'(sort_wr_req_o), 0);
        check("reset wr_data", int'(sort_wr_data_o), 0);
        check("reset run", int'(sort_run_o), 0);
        check("reset pkt_len", int'(pkt_len_o), 0);
        check("reset overflow", int'(overflow_o), 0);
        check("reset busy", int'(busy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle ready", int'(in_ready_o), 1);

        // Packet {5,1,7}
        pkt_q = '{8'd5, 8'd1, 8'd7};
        send_pkt();
        repeat (3) @(negedge clk);
        check("srst to first write", first_wr_cyc - srst_cyc, 2);
        check("last write to run", run_cyc - last_wr_cyc, 1);
        check("pkt_len 3", int'(pkt_len_o), 3);
        check("busy in wait_out", int'(busy_o), 1);
        in_valid = 1'b1;
        #1;
        check("ready in wait_out", int'(in_ready_o), 0);
        in_valid = 1'b0;
        out_eop_hs();

        // Single-word packet
        pkt_q = '{8'h3C};
        send_pkt();
        repeat (3) @(negedge clk);
        check("pkt_len 1", int'(pkt_len_o), 1);
        check("single run after write", run_cyc - last_wr_cyc, 1);
        out_eop_hs();

        // Oversize packet of 10 words
        pkt_q = '{8'd20, 8'd19, 8'd18, 8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11};
        send_pkt();
`ifdef SORT_LOADER_OVERFLOW_DROP_EN
        #1;
        check("drop idle after eop", int'(busy_o), 0);
`endif
        repeat (3) @(negedge clk);
        check("overflow set", int'(overflow_o), 1);
        check("pkt_len saturated", int'(pkt_len_o), CAP);
`ifndef SORT_LOADER_OVERFLOW_DROP_EN
        out_eop_hs();
`endif

        // Two strays in IDLE, then a 2-word packet
        send(8'hAA, 1'b0, 1'b0, r);
        check("stray 1 accepted", int'(r), 1);
        send(8'hBB, 1'b0, 1'b0, r);
        check("stray 2 accepted", int'(r), 1);
        idle_in();
        #1;
        check("strays leave idle", int'(busy_o), 0);
        pkt_q = '{8'd2, 8'd3};
        send_pkt();
        repeat (3) @(negedge clk);
        check("pkt_len 2", int'(pkt_len_o), 2);
        check("overflow cleared", int'(overflow_o), 0);
        out_eop_hs();

        // sop on the 4th word restarts the load
        exp_q.push_back(EvSrst);
        exp_q.push_back(11);
        send(8'd11, 1'b1, 1'b0, r);
        exp_q.push_back(12);
        send(8'd12, 1'b0, 1'b0, r);
        exp_q.push_back(13);
        send(8'd13, 1'b0, 1'b0, r);
        exp_q.push_back(EvSrst);
        exp_q.push_back(21);
        send(8'd21, 1'b1, 1'b0, r);
        check("ready low on mid-packet sop", int'(r), 0);
        exp_q.push_back(22);
        send(8'd22, 1'b0, 1'b1, r);
        exp_q.push_back(EvRun);
        idle_in();
        repeat (3) @(negedge clk);
        check("restart pkt_len", int'(pkt_len_o), 2);
        out_eop_hs();

        // Reset in the middle of LOAD
        exp_q.push_back(EvSrst);
        exp_q.push_back(31);
        send(8'd31, 1'b1, 1'b0, r);
        exp_q.push_back(32);
        send(8'd32, 1'b0, 1'b0, r);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_sop = 1'b0;
        @(posedge clk);
        #1;
        check("mid rst wr_req", int'(sort_wr_req_o), 0);
        check("mid rst pkt_len", int'(pkt_len_o), 0);
        check("mid rst busy", int'(busy_o), 0);
        check("mid rst run", int'(sort_run_o), 0);
        check("mid rst ready", int'(in_ready_o), 0);
        @(negedge clk);
        rst = 1'b0;
        pkt_q = '{8'd9, 8'd4};
        send_pkt();
        repeat (3) @(negedge clk);
        check("post reset pkt_len", int'(pkt_len_o), 2);
        out_eop_hs();

        repeat (5) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
